io_hub: RTL and testbench

Parametrised I/O-region decoder and read-data/ack concentrator for the RISC5 CPU bus.
- Maps a configurable I/O window of 2^IO_SPAN_LOG2 words onto N_DEV device slots. Each slot is 2^DEV_SHIFT words.
- Multiplexes device read data and acks back to the CPU.
- Guards every access with a timeout watchdog.
- Adds an internal error-status register.
- Sits between the CPU bus and the peripheral strobes (timer, board I/O, serial, SD card, keyboard) in the top level.

---
 rtl/io_hub.sv | 208 ++++++++++++++++++++
 tb/tb_io_hub.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_hub.sv
// io_hub : I/O-region decoder and read-data/ack concentrator for the RISC5 CPU bus.
//
// Purpose
//   Decodes a 2^IO_SPAN_LOG2-word I/O window into N_DEV device slots of
//   2^DEV_SHIFT words each, and muxes the selected device's read data and ack
//   back to the CPU with zero added latency. The last word of the window is
//   an internal error-status register (STAT). Every device access is watched
//   by a timeout counter. Unmapped slots and timeouts are answered by the hub
//   itself and logged in STAT.
//
// Optional build macro
//   IO_HUB_ERR_IRQ_EN : adds output err_irq, a sticky error flag that is
//                       cleared by any write to STAT.
//
// Ports
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   bus_stb   in   CPU bus strobe
//   bus_we    in   CPU write enable
//   bus_addr  in   CPU word address [ADDR_W-1:0]
//   bus_din   out  read data to CPU [31:0]
//   bus_ack   out  acknowledge to CPU
//   dev_stb   out  one-hot device strobes [N_DEV-1:0]
//   dev_dout  in   device read data, slot i at [32i+31:32i]
//   dev_ack   in   device acknowledges [N_DEV-1:0]
//   hit       out  access falls inside the I/O window
//   err_irq   out  sticky error flag (only with IO_HUB_ERR_IRQ_EN)
module io_hub #(
  parameter int unsigned       ADDR_W       = 22,
  parameter logic [ADDR_W-1:0] IO_BASE      = 22'h3FFFF0,
  parameter int unsigned       IO_SPAN_LOG2 = 4,
  parameter int unsigned       DEV_SHIFT    = 0,
  parameter int unsigned       N_DEV        = 8,
  parameter int unsigned       TMO          = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bus_stb,
  input  logic                bus_we,
  input  logic [ADDR_W-1:0]   bus_addr,
  output logic [31:0]         bus_din,
  output logic                bus_ack,
  output logic [N_DEV-1:0]    dev_stb,
  input  logic [32*N_DEV-1:0] dev_dout,
  input  logic [N_DEV-1:0]    dev_ack,
  output logic                hit
`ifdef IO_HUB_ERR_IRQ_EN
  ,
  output logic                err_irq
`endif
);

  localparam logic [15:0] TMO_V         = 16'(TMO);
  localparam logic [1:0]  CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0]  CAUSE_UNMAP   = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    IACK,
    TACK
  } state_e;

  state_e state_q, state_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic [7:0]  last_off_q, last_off_d;
  logic        err_irq_q, err_irq_d;

  logic [IO_SPAN_LOG2-1:0] off;
  logic [IO_SPAN_LOG2-1:0] idx;
  logic        is_stat;
  logic        mapped;
  logic [31:0] sel_dout;
  logic        sel_ack;
  logic [31:0] stat_val;
  logic        rec_err;
  logic [1:0]  rec_cause;
  logic        clr;

  // Address decode and read-path selection; purely combinational so a
  // zero-wait device is answered in the same cycle as the strobe.
  always_comb begin
    off      = bus_addr[IO_SPAN_LOG2-1:0];
    idx      = off >> DEV_SHIFT;
    hit      = bus_stb && (bus_addr[ADDR_W-1:IO_SPAN_LOG2] == IO_BASE[ADDR_W-1:IO_SPAN_LOG2]);
    is_stat  = (off == '1);
    mapped   = !is_stat && (32'(idx) < N_DEV);
    sel_dout = 32'h0;
    sel_ack  = 1'b0;
    dev_stb  = '0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (32'(idx) == i) begin
        sel_dout   = dev_dout[32*i +: 32];
        sel_ack    = dev_ack[i];
        dev_stb[i] = hit && mapped;
      end
    end
    stat_val = {err_cnt_q, cause_q, 6'b0, last_off_q};
  end

  // Access FSM: next state, watchdog count, error events and the bus
  // response. Hub-generated acks (IACK/TACK) override the device path.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    rec_err   = 1'b0;
    rec_cause = 2'b00;
    clr       = 1'b0;
    bus_ack   = 1'b0;
    bus_din   = 32'h0;
    if (hit && mapped) begin
      bus_ack = sel_ack;
      bus_din = sel_dout;
    end
    case (state_q)
      IDLE: begin
        if (hit) begin
          if (is_stat) begin
            state_d = IACK;
            clr     = bus_we;
          end else if (!mapped) begin
            state_d   = IACK;
            rec_err   = 1'b1;
            rec_cause = CAUSE_UNMAP;
          end else if (!sel_ack) begin
            state_d = WAIT;
            tcnt_d  = 16'd1;
          end
        end
      end
      WAIT: begin
        // Device ack is checked before the limit so a reply arriving in the
        // last allowed cycle still wins over the timeout.
        if (!bus_stb) begin
          state_d = IDLE;
        end else if (sel_ack) begin
          state_d = IDLE;
        end else if (tcnt_q == TMO_V) begin
          state_d   = TACK;
          rec_err   = 1'b1;
          rec_cause = CAUSE_TIMEOUT;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      IACK: begin
        bus_ack = hit;
        bus_din = (hit && is_stat && !bus_we) ? stat_val : 32'h0;
        state_d = IDLE;
      end
      TACK: begin
        bus_ack = hit;
        bus_din = hit ? 32'hFFFF_FFFF : 32'h0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset arriving mid-access must not let a device ack through.
    if (!rst_n) begin
      bus_ack = 1'b0;
    end
  end

  // Error log update; a STAT write clears everything and beats a
  // simultaneous error record.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    cause_d    = cause_q;
    last_off_d = last_off_q;
    err_irq_d  = err_irq_q;
    if (clr) begin
      err_cnt_d  = 16'h0;
      cause_d    = 2'b00;
      last_off_d = 8'h0;
      err_irq_d  = 1'b0;
    end else if (rec_err) begin
      err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
      cause_d    = rec_cause;
      last_off_d = 8'(off);
      err_irq_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tcnt_q     <= 16'h0;
      err_cnt_q  <= 16'h0;
      cause_q    <= 2'b00;
      last_off_q <= 8'h0;
      err_irq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      err_cnt_q  <= err_cnt_d;
      cause_q    <= cause_d;
      last_off_q <= last_off_d;
      err_irq_q  <= err_irq_d;
    end
  end

`ifdef IO_HUB_ERR_IRQ_EN
  assign err_irq = err_irq_q;
`endif

endmodule

// File: tb/tb_io_hub.sv
// tb_io_hub : directed, table-driven bench for io_hub with default parameters.
module tb_io_hub;

   localparam logic [21:0] STAT_ADDR = 22'h3FFFFF;

   logic          clk;
   logic          rst_n;
   logic          bus_stb;
   logic          bus_we;
   logic [21:0]   bus_addr;
   logic [31:0]   bus_din;
   logic          bus_ack;
   logic [7:0]    dev_stb;
   logic [255:0]  dev_dout;
   logic [7:0]    dev_ack;
   logic          hit;
`ifdef IO_HUB_ERR_IRQ_EN
   logic          err_irq;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        stb;
      logic        we;
      logic [21:0] addr;
      logic [7:0]  ack;
      logic        expHit;
      logic [7:0]  expStb;
      logic        expAck;
      logic [31:0] expDin;
   } vec_t;

   vec_t vecs [10];

   io_hub dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus_stb  (bus_stb),
      .bus_we   (bus_we),
      .bus_addr (bus_addr),
      .bus_din  (bus_din),
      .bus_ack  (bus_ack),
      .dev_stb  (dev_stb),
      .dev_dout (dev_dout),
      .dev_ack  (dev_ack),
      .hit      (hit)
`ifdef IO_HUB_ERR_IRQ_EN
      ,
      .err_irq  (err_irq)
`endif
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and land on the falling edge, away from the active edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drive bus inputs and let combinational outputs settle.
   task automatic applyStimulus(input logic stb, input logic we, input logic [21:0] addr,
                                input logic [7:0] ack);
      bus_stb  = stb;
      bus_we   = we;
      bus_addr = addr;
      dev_ack  = ack;
      #1;
   endtask

   // Single comparison against a bench-side expected value.
   task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic checkOutput(input string name, input logic eHit, input logic [7:0] eStb,
                              input logic eAck, input logic [31:0] eDin);
      checkVal({name, ".hit"}, {31'b0, hit}, {31'b0, eHit});
      checkVal({name, ".dev_stb"}, {24'b0, dev_stb}, {24'b0, eStb});
      checkVal({name, ".ack"}, {31'b0, bus_ack}, {31'b0, eAck});
      checkVal({name, ".din"}, bus_din, eDin);
   endtask

   task automatic checkIrq(input string name, input logic want);
`ifdef IO_HUB_ERR_IRQ_EN
      checkVal(name, {31'b0, err_irq}, {31'b0, want});
`else
      if (name.len() == 0 && want) $display("[TB] unused");
`endif
   endtask

   // STAT read: no ack in the strobe cycle, registered ack one cycle later.
   task automatic readStat(input string name, input logic [31:0] want);
      applyStimulus(1'b1, 1'b0, STAT_ADDR, 8'h00);
      checkOutput({name, ".c0"}, 1'b1, 8'h00, 1'b0, 32'h0);
      tick();
      checkOutput({name, ".c1"}, 1'b1, 8'h00, 1'b1, want);
      applyStimulus(1'b0, 1'b0, 22'h0, 8'h00);
      tick();
   endtask

   task automatic writeStat(input string name);
      applyStimulus(1'b1, 1'b1, STAT_ADDR, 8'h00);
      tick();
      checkOutput(name, 1'b1, 8'h00, 1'b1, 32'h0);
      applyStimulus(1'b0, 1'b0, 22'h0, 8'h00);
      tick();
   endtask

   // Unmapped access: hub answers one cycle later with zero data.
   task automatic unmapped(input string name, input logic [21:0] addr);
      applyStimulus(1'b1, 1'b0, addr, 8'h00);
      checkOutput({name, ".c0"}, 1'b1, 8'h00, 1'b0, 32'h0);
      tick();
      checkOutput({name, ".c1"}, 1'b1, 8'h00, 1'b1, 32'h0);
      applyStimulus(1'b0, 1'b0, 22'h0, 8'h00);
      tick();
   endtask

   initial begin : main
      int n;
      bit seen;

      for (int i = 0; i < 8; i++) begin
         dev_dout[32*i +: 32] = (i == 1) ? 32'h12345678 : (32'hC0DE0000 | 32'(i));
      end

      vecs[0] = '{"zw_slot1",   1'b1, 1'b0, 22'h3FFFF1, 8'h02, 1'b1, 8'h02, 1'b1, 32'h12345678};
      vecs[1] = '{"zw_slot0",   1'b1, 1'b0, 22'h3FFFF0, 8'h01, 1'b1, 8'h01, 1'b1, 32'hC0DE0000};
      vecs[2] = '{"zw_slot7",   1'b1, 1'b0, 22'h3FFFF7, 8'h80, 1'b1, 8'h80, 1'b1, 32'hC0DE0007};
      vecs[3] = '{"wait_slot5", 1'b1, 1'b0, 22'h3FFFF5, 8'h00, 1'b1, 8'h20, 1'b0, 32'hC0DE0005};
      vecs[4] = '{"other_ack",  1'b1, 1'b0, 22'h3FFFF5, 8'hDF, 1'b1, 8'h20, 1'b0, 32'hC0DE0005};
      vecs[5] = '{"no_stb",     1'b0, 1'b0, 22'h3FFFF1, 8'hFF, 1'b0, 8'h00, 1'b0, 32'h0};
      vecs[6] = '{"below_win",  1'b1, 1'b0, 22'h3FFFE1, 8'hFF, 1'b0, 8'h00, 1'b0, 32'h0};
      vecs[7] = '{"low_addr",   1'b1, 1'b0, 22'h000001, 8'hFF, 1'b0, 8'h00, 1'b0, 32'h0};
      vecs[8] = '{"stat_c0",    1'b1, 1'b0, 22'h3FFFFF, 8'hFF, 1'b1, 8'h00, 1'b0, 32'h0};
      vecs[9] = '{"zw_write2",  1'b1, 1'b1, 22'h3FFFF2, 8'h04, 1'b1, 8'h04, 1'b1, 32'hC0DE0002};

      // Reset state with idle bus.
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 22'h0, 8'h00);
      repeat (3) tick();
      checkOutput("reset", 1'b0, 8'h00, 1'b0, 32'h0);
      checkIrq("reset.irq", 1'b0);
      rst_n = 1'b1;
      tick();

      // Single-cycle decode/mux vectors, each followed by an idle cycle.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].stb, vecs[i].we, vecs[i].addr, vecs[i].ack);
         checkOutput(vecs[i].name, vecs[i].expHit, vecs[i].expStb, vecs[i].expAck, vecs[i].expDin);
         tick();
         applyStimulus(1'b0, 1'b0, 22'h0, 8'h00);
         tick();
      end
      readStat("stat_clean", 32'h0);

      // Timeout on slot 3: hub ack exactly 256 cycles after the strobe.
      applyStimulus(1'b1, 1'b0, 22'h3FFFF3, 8'h00);
      checkOutput("to_start", 1'b1, 8'h08, 1'b0, 32'hC0DE0003);
      n = 0;
      seen = 0;
      while (!seen && n < 400) begin
         tick();
         n++;
         if (bus_ack) seen = 1;
      end
      checkVal("to_latency", 32'(n), 32'd256);
      checkVal("to_din", bus_din, 32'hFFFFFFFF);
      checkVal("to_devstb", {24'b0, dev_stb}, 32'h08);
      applyStimulus(1'b0, 1'b0, 22'h0, 8'h00);
      tick();
      checkIrq("to_irq", 1'b1);
      readStat("to_stat", 32'h0001_4003);
      writeStat("to_clr");
      readStat("to_stat_clr", 32'h0);
      checkIrq("to_irq_clr", 1'b0);

      // Unmapped slot (off = A).
      applyStimulus(1'b1, 1'b0, 22'h3FFFFA, 8'h00);
      checkOutput("um_c0", 1'b1, 8'h00, 1'b0, 32'h0);
      checkIrq("um_irq0", 1'b0);
      tick();
      checkOutput("um_c1", 1'b1, 8'h00, 1'b1, 32'h0);
      checkIrq("um_irq1", 1'b1);
      applyStimulus(1'b0, 1'b0, 22'h0, 8'h00);
      tick();
      readStat("um_stat", 32'h0001_800A);
      writeStat("um_clr");
      readStat("um_stat_clr", 32'h0);
      checkIrq("um_irq_clr", 1'b0);

      // Device ack in the very cycle tcnt reaches TMO: device wins.
      applyStimulus(1'b1, 1'b0, 22'h3FFFF4, 8'h00);
      repeat (254) tick();
      checkOutput("tie_c254", 1'b1, 8'h10, 1'b0, 32'hC0DE0004);
      tick();
      applyStimulus(1'b1, 1'b0, 22'h3FFFF4, 8'h10);
      checkOutput("tie_c255", 1'b1, 8'h10, 1'b1, 32'hC0DE0004);
      tick();
      applyStimulus(1'b0, 1'b0, 22'h0, 8'h00);
      checkOutput("tie_after", 1'b0, 8'h00, 1'b0, 32'h0);
      tick();
      readStat("tie_stat", 32'h0);

      // Saturation: preload the counter near the top, then log two errors.
      force dut.err_cnt_q = 16'hFFFE;
      tick();
      release dut.err_cnt_q;
      unmapped("sat_a", 22'h3FFFFE);
      readStat("sat_stat_a", 32'hFFFF_800E);
      unmapped("sat_b", 22'h3FFFF9);
      readStat("sat_stat_b", 32'hFFFF_8009);
      writeStat("sat_clr");
      readStat("sat_stat_clr", 32'h0);

      // Reset during WAIT: no ack, error log cleared, FSM back to IDLE.
      unmapped("rw_pre", 22'h3FFFFB);
      applyStimulus(1'b1, 1'b0, 22'h3FFFF6, 8'h00);
      tick();
      tick();
      rst_n = 1'b0;
      applyStimulus(1'b1, 1'b0, 22'h3FFFF6, 8'h40);
      checkVal("rw_no_ack", {31'b0, bus_ack}, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 22'h0, 8'h00);
      checkOutput("rw_idle", 1'b0, 8'h00, 1'b0, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      checkIrq("rw_irq", 1'b0);
      readStat("rw_stat", 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
